// File: rtl/cpu_mem_arbiter_pkg.sv
// mem_arb_pkg: shared types and default widths for the CPU/SRAM arbiter slice.
//   arb_state_e : arbiter FSM states
//   master_e    : requesting master (M0 = instruction fetch, M1 = data port)
//   DEF_*       : default widths, overridable per instance
//   cnt_bits()  : bits needed to hold a counter value in 0..max
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_BITS  = 32;
    localparam int unsigned DEF_DATA_BITS  = 32;
    localparam int unsigned DEF_WEB_BITS   = 4;
    localparam int unsigned DEF_READ_LAT   = 1;
    localparam int unsigned DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        WAIT,
        DONE
    } arb_state_e;

    typedef enum logic {
        M0,
        M1
    } master_e;

    function automatic int unsigned cnt_bits(input int unsigned max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// cpu_mem_arbiter_if: bundles the CPU fetch port (M0), CPU data port (M1)
// and the SRAM wrapper signals seen by the arbiter.
//   slave  modport : the arbiter side (takes requests, drives SRAM)
//   master modport : the CPU/SRAM side (issues requests, returns SRAM data)
interface cpu_mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
    parameter int unsigned DATA_BITS = DEF_DATA_BITS,
    parameter int unsigned WEB_BITS  = DEF_WEB_BITS
);
    logic                 m0_req_i;
    logic [ADDR_BITS-1:0] m0_addr_i;
    logic [DATA_BITS-1:0] m0_rdata_o;
    logic                 m0_wait_o;

    logic                 m1_req_i;
    logic                 m1_write_i;
    logic [WEB_BITS-1:0]  m1_web_i;
    logic [ADDR_BITS-1:0] m1_addr_i;
    logic [DATA_BITS-1:0] m1_wdata_i;
    logic [DATA_BITS-1:0] m1_rdata_o;
    logic                 m1_wait_o;

    logic                 sram_cs_o;
    logic [WEB_BITS-1:0]  sram_web_o;
    logic [ADDR_BITS-1:0] sram_addr_o;
    logic [DATA_BITS-1:0] sram_di_o;
    logic [DATA_BITS-1:0] sram_do_i;

    modport slave (
        input  m0_req_i, m0_addr_i,
        output m0_rdata_o, m0_wait_o,
        input  m1_req_i, m1_write_i, m1_web_i, m1_addr_i, m1_wdata_i,
        output m1_rdata_o, m1_wait_o,
        output sram_cs_o, sram_web_o, sram_addr_o, sram_di_o,
        input  sram_do_i
    );

    modport master (
        output m0_req_i, m0_addr_i,
        input  m0_rdata_o, m0_wait_o,
        output m1_req_i, m1_write_i, m1_web_i, m1_addr_i, m1_wdata_i,
        input  m1_rdata_o, m1_wait_o,
        input  sram_cs_o, sram_web_o, sram_addr_o, sram_di_o,
        output sram_do_i
    );
endinterface

// File: rtl/cpu_mem_arbiter_pick.sv
// arb_pick: combinational winner selection.
//   m0_req, m1_req : pending requests
//   starve_cnt     : consecutive M1 grants taken while M0 was waiting
//   grant          : chosen master
//   valid          : at least one request pending
// M1 wins any contest unless M0 has been starved STARVE_MAX times in a row.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX,
    parameter int unsigned CNT_BITS   = 3
) (
    input  logic                m0_req,
    input  logic                m1_req,
    input  logic [CNT_BITS-1:0] starve_cnt,
    output master_e             grant,
    output logic                valid
);
    always_comb begin
        valid = m0_req | m1_req;
        grant = M0;
        if (m1_req && !(m0_req && starve_cnt == CNT_BITS'(STARVE_MAX))) begin
            grant = M1;
        end
    end
endmodule

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one synchronous single-port SRAM between the CPU
// instruction-fetch port (M0, read-only) and data port (M1, read/write).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : cpu_mem_arbiter_if.slave (M0/M1 request ports, SRAM port)
// Access sequence IDLE -> ACC -> (WAIT for reads) -> DONE -> IDLE; the
// winner's wait drops only during DONE. SRAM controls are all registered.
module cpu_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = DEF_ADDR_BITS,
    parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
    parameter int unsigned WEB_BITS   = DEF_WEB_BITS,
    parameter int unsigned READ_LAT   = DEF_READ_LAT,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input logic               clk,
    input logic               rst,
    cpu_mem_arbiter_if.slave  bus
);
    localparam int unsigned LAT_W = cnt_bits(READ_LAT);
    localparam int unsigned STV_W = cnt_bits(STARVE_MAX);

    arb_state_e           state, state_nx;
    master_e              grant, pick_grant;
    logic                 pick_valid;
    logic [LAT_W-1:0]     lat_cnt;
    logic [STV_W-1:0]     starve_cnt;
    logic                 write_q;
    logic                 cs_q;
    logic [WEB_BITS-1:0]  web_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] di_q;
    logic [DATA_BITS-1:0] rdata0_q, rdata1_q;

    arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_BITS   (STV_W)
    ) u_pick (
        .m0_req     (bus.m0_req_i),
        .m1_req     (bus.m1_req_i),
        .starve_cnt (starve_cnt),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (pick_valid) state_nx = ACC;
            ACC:     state_nx = write_q ? DONE : WAIT;
            WAIT:    if (lat_cnt == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant      <= M0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            write_q    <= 1'b0;
            cs_q       <= 1'b0;
            web_q      <= '1;
            addr_q     <= '0;
            di_q       <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            cs_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant <= pick_grant;
                        cs_q  <= 1'b1;
                        if (pick_grant == M1) begin
                            addr_q  <= bus.m1_addr_i;
                            write_q <= bus.m1_write_i;
                            web_q   <= bus.m1_write_i ? bus.m1_web_i : '1;
                            di_q    <= bus.m1_wdata_i;
                            // Count only grants that actually made M0 wait.
                            if (bus.m0_req_i && starve_cnt != STV_W'(STARVE_MAX)) begin
                                starve_cnt <= starve_cnt + 1'b1;
                            end
                        end else begin
                            addr_q     <= bus.m0_addr_i;
                            write_q    <= 1'b0;
                            web_q      <= '1;
                            starve_cnt <= '0;
                        end
                    end
                end
                ACC: lat_cnt <= LAT_W'(READ_LAT - 1);
                WAIT: begin
                    if (lat_cnt == '0) begin
                        if (grant == M0) rdata0_q <= bus.sram_do_i;
                        else             rdata1_q <= bus.sram_do_i;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.m0_wait_o   = bus.m0_req_i & ~(state == DONE && grant == M0);
        bus.m1_wait_o   = bus.m1_req_i & ~(state == DONE && grant == M1);
        bus.m0_rdata_o  = rdata0_q;
        bus.m1_rdata_o  = rdata1_q;
        bus.sram_cs_o   = cs_q;
        bus.sram_web_o  = web_q;
        bus.sram_addr_o = addr_q;
        bus.sram_di_o   = di_q;
    end
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: scoreboard bench for cpu_mem_arbiter (READ_LAT=1,
// STARVE_MAX=4). Stimulus pushes expected accesses per master; a monitor
// compares them whenever a master sees its wait drop with req high.
module tb_cpu_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_mem_arbiter_if #(.ADDR_BITS(32), .DATA_BITS(32), .WEB_BITS(4)) bus ();

    cpu_mem_arbiter #(
        .ADDR_BITS  (32),
        .DATA_BITS  (32),
        .WEB_BITS   (4),
        .READ_LAT   (1),
        .STARVE_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        wr;
        logic [3:0]  web;
        logic [31:0] addr;
        logic [31:0] di;
        logic [31:0] rdata;
        int          cs_cyc;
        int          done_cyc;
    } exp_t;

    exp_t exp0_q[$];
    exp_t exp1_q[$];
    int   order_q[$];

    int cyc    = 0;
    int checks = 0;
    int passes = 0;

    logic [31:0] starve_data [0:5] = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002,
                                       32'hA000_0003, 32'hA000_0004, 32'hA000_0005};

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: one-cycle read latency, active-low byte enables.
    logic [31:0] mem [0:255];
    logic [31:0] sram_do;
    assign bus.sram_do_i = sram_do;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[64]  <= 32'hDEAD_BEEF;
            mem[128] <= 32'hAABB_CCDD;
            mem[130] <= 32'h55AA_55AA;
            for (int k = 0; k < 6; k++) mem[192 + k] <= 32'hA000_0000 + 32'(k);
            sram_do <= '0;
        end else if (bus.sram_cs_o) begin
            if (&bus.sram_web_o) begin
                sram_do <= mem[bus.sram_addr_o[9:2]];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (!bus.sram_web_o[b]) mem[bus.sram_addr_o[9:2]][8*b +: 8] <= bus.sram_di_o[8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    endtask

    // Monitor
    logic        prev_cs = 1'b0;
    logic [31:0] seen_addr = '0;
    logic [31:0] seen_di = '0;
    logic [3:0]  seen_web = '0;
    int          seen_cyc = 0;

    task automatic complete(input int m);
        exp_t e;
        if ((m == 0) ? (exp0_q.size() == 0) : (exp1_q.size() == 0)) begin
            checks++;
            $display("FAIL unexpected_done: M%0d completed with no access outstanding (cycle %0d)", m, cyc);
            return;
        end
        e = (m == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
        if (order_q.size() > 0) chk("grant_order", 32'(m), 32'(order_q.pop_front()));
        chk("sram_addr", seen_addr, e.addr);
        chk("sram_web", 32'(seen_web), 32'(e.web));
        if (e.wr) chk("sram_di", seen_di, e.di);
        else if (m == 0) chk("m0_rdata", bus.m0_rdata_o, e.rdata);
        else chk("m1_rdata", bus.m1_rdata_o, e.rdata);
        if (e.cs_cyc >= 0) chk("cs_cycle", 32'(seen_cyc), 32'(e.cs_cyc));
        if (e.done_cyc >= 0) chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_cs = 1'b0;
        end else begin
            if (bus.sram_cs_o) begin
                chk("cs_single_cycle", 32'(prev_cs), 32'd0);
                seen_addr = bus.sram_addr_o;
                seen_di   = bus.sram_di_o;
                seen_web  = bus.sram_web_o;
                seen_cyc  = cyc;
            end
            prev_cs = bus.sram_cs_o;
            if (bus.m0_req_i && !bus.m0_wait_o) complete(0);
            if (bus.m1_req_i && !bus.m1_wait_o) complete(1);
        end
    end

    // Driver helpers
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input int m, input logic wr, input logic [3:0] web,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (m == 0) begin
            bus.m0_req_i  = 1'b1;
            bus.m0_addr_i = addr;
        end else begin
            bus.m1_req_i   = 1'b1;
            bus.m1_write_i = wr;
            bus.m1_web_i   = web;
            bus.m1_addr_i  = addr;
            bus.m1_wdata_i = wdata;
        end
    endtask

    // Offsets are relative to the IDLE cycle in which the request is raised;
    // a negative offset means the timing is not predicted for that access.
    task automatic access(input int m, input logic wr, input logic [3:0] web,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int cs_off, input int done_off,
                          input logic release_req);
        exp_t e;
        int   t;
        logic done;
        t          = cyc;
        e.wr       = wr;
        e.web      = wr ? web : 4'hF;
        e.addr     = addr;
        e.di       = wdata;
        e.rdata    = rdata;
        e.cs_cyc   = (cs_off < 0) ? -1 : t + cs_off;
        e.done_cyc = (done_off < 0) ? -1 : t + done_off;
        if (m == 0) exp0_q.push_back(e);
        else        exp1_q.push_back(e);
        drive(m, wr, web, addr, wdata);
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            done = (m == 0) ? (bus.m0_req_i && !bus.m0_wait_o) : (bus.m1_req_i && !bus.m1_wait_o);
        end
        #1;
        if (!done) begin
            checks++;
            $display("FAIL timeout: M%0d access to 0x%08h not complete after 60 cycles", m, addr);
        end
        if (release_req) begin
            if (m == 0) bus.m0_req_i = 1'b0;
            else        bus.m1_req_i = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.m0_req_i   = 1'b0;
        bus.m0_addr_i  = '0;
        bus.m1_req_i   = 1'b0;
        bus.m1_write_i = 1'b0;
        bus.m1_web_i   = 4'hF;
        bus.m1_addr_i  = '0;
        bus.m1_wdata_i = '0;
        rst = 1'b1;
        repeat (3) step();

        // Reset state
        chk("rst_cs", 32'(bus.sram_cs_o), 32'd0);
        chk("rst_web", 32'(bus.sram_web_o), 32'hF);
        chk("rst_addr", bus.sram_addr_o, 32'h0);
        chk("rst_di", bus.sram_di_o, 32'h0);
        chk("rst_m0_rdata", bus.m0_rdata_o, 32'h0);
        chk("rst_m1_rdata", bus.m1_rdata_o, 32'h0);
        chk("rst_m0_wait", 32'(bus.m0_wait_o), 32'd0);
        chk("rst_m1_wait", 32'(bus.m1_wait_o), 32'd0);
        rst = 1'b0;
        step(); step();

        // M0 fetch alone: cs at t+1, done at t+3
        access(0, 1'b0, 4'hF, 32'h100, 32'h0, 32'hDEAD_BEEF, 1, 3, 1'b1);
        step(); step();

        // Reset during WAIT aborts the read and clears rdata
        drive(1, 1'b0, 4'hF, 32'h300, 32'h0);
        drive(0, 1'b0, 4'hF, 32'h100, 32'h0);
        step(); step();
        rst = 1'b1;
        #1;
        chk("midrst_cs", 32'(bus.sram_cs_o), 32'd0);
        chk("midrst_m0_wait", 32'(bus.m0_wait_o), 32'd1);
        chk("midrst_m1_wait", 32'(bus.m1_wait_o), 32'd1);
        chk("midrst_m0_rdata", bus.m0_rdata_o, 32'h0);
        chk("midrst_m1_rdata", bus.m1_rdata_o, 32'h0);
        bus.m0_req_i = 1'b0;
        bus.m1_req_i = 1'b0;
        #1;
        chk("midrst_m0_wait_noreq", 32'(bus.m0_wait_o), 32'd0);
        chk("midrst_m1_wait_noreq", 32'(bus.m1_wait_o), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("postrst_cs_idle", 32'(bus.sram_cs_o), 32'd0);
        end

        // Both request: M1 byte-masked write first, then M0 fetch
        order_q.push_back(1);
        order_q.push_back(0);
        fork
            access(1, 1'b1, 4'b1100, 32'h200, 32'h1234_5678, 32'h0, 1, 2, 1'b1);
            access(0, 1'b0, 4'hF, 32'h100, 32'h0, 32'hDEAD_BEEF, 4, 6, 1'b1);
        join
        step(); step();

        // Read back merged word 0xAABBCCDD with low half replaced
        access(1, 1'b0, 4'hF, 32'h200, 32'h0, 32'hAABB_5678, 1, 3, 1'b1);
        step(); step();

        // No-op write (all byte enables off) still completes at t+2
        access(1, 1'b1, 4'hF, 32'h200, 32'hFFFF_FFFF, 32'h0, 1, 2, 1'b1);
        step(); step();
        access(1, 1'b0, 4'hF, 32'h200, 32'h0, 32'hAABB_5678, 1, 3, 1'b1);
        step(); step();

        // Starvation: M0 held, M1 six back-to-back reads
        for (int k = 0; k < 7; k++) order_q.push_back((k == 4) ? 0 : 1);
        fork
            access(0, 1'b0, 4'hF, 32'h100, 32'h0, 32'hDEAD_BEEF, 17, 19, 1'b1);
            begin
                for (int k = 0; k < 6; k++) begin
                    access(1, 1'b0, 4'hF, 32'h300 + 32'(4 * k), 32'h0, starve_data[k], -1, -1, k == 5);
                end
            end
        join
        step(); step();

        // M1 drops req during WAIT: read still lands, M0 follows immediately
        fork
            access(0, 1'b0, 4'hF, 32'h100, 32'h0, 32'hDEAD_BEEF, 5, 7, 1'b1);
            begin
                drive(1, 1'b0, 4'hF, 32'h208, 32'h0);
                step(); step();
                bus.m1_req_i = 1'b0;
                step(); step();
                chk("m1_rdata_after_drop", bus.m1_rdata_o, 32'h55AA_55AA);
            end
        join
        step(); step();

        chk("queues_drained", 32'(exp0_q.size() + exp1_q.size() + order_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
